// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the RV32I pipeline front end
package pipeline_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {pc, inst} with flush; head is registered storage, never bypassed
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t pushEntry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;

  // Flush outranks push/pop so a redirect always leaves the queue empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wrPtr] <= pushEntry;
  end

  assign head = mem[rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: owns the PC, credit-limited imem reads, prefetch queue to IF/ID
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = PC_W,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pcAdd4,
  output logic [31:0]       out_inst,
  output logic [CW-1:0]     q_count
);

  localparam logic [CW:0] CAPACITY = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] inflightPc;
  logic              inflight;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CW:0]       used;
  logic [CW-1:0]     count;
  fetch_entry_t      headEntry;
  fetch_entry_t      pushEntry;

  // An outstanding read reserves a slot, so a returning word always has room.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = reset && !redirect && (used < CAPACITY);
  assign imem_req  = issue;
  assign imem_addr = fetchPc;

  assign push           = inflight && !redirect;
  assign pop            = out_valid && out_ready;
  assign pushEntry.pc   = inflightPc;
  assign pushEntry.inst = imem_rdata;
  assign q_count        = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetchPc    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
    end else if (redirect) begin
      fetchPc  <= redirect_pc & ~ADDR_W'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetchPc    <= fetchPc + ADDR_W'(4);
        inflightPc <= fetchPc;
      end
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .head      (headEntry),
    .count     (count)
  );

  always_comb begin
    out_valid  = (count != '0);
    out_pc     = '0;
    out_pcAdd4 = '0;
    out_inst   = '0;
    if (out_valid) begin
      out_pc     = headEntry.pc;
      out_pcAdd4 = headEntry.pc + ADDR_W'(4);
      out_inst   = headEntry.inst;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPc;
  logic [31:0] outPcAdd4;
  logic [31:0] outInst;
  logic [2:0]  qCount;

  logic        resetW;
  logic        imemReqW;
  logic [31:0] imemAddrW;
  logic [31:0] imemRdataW;
  logic        redirectW;
  logic [31:0] redirectPcW;
  logic        outValidW;
  logic        outReadyW;
  logic [31:0] outPcW;
  logic [31:0] outPcAdd4W;
  logic [31:0] outInstW;
  logic [2:0]  qCountW;

  int nApplied = 0;
  int nMiss = 0;

  fetch_unit dut (
    .clock(clock), .reset(reset), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_rdata(imemRdata), .redirect(redirect), .redirect_pc(redirectPc),
    .out_valid(outValid), .out_ready(outReady), .out_pc(outPc),
    .out_pcAdd4(outPcAdd4), .out_inst(outInst), .q_count(qCount)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dutW (
    .clock(clock), .reset(resetW), .imem_req(imemReqW), .imem_addr(imemAddrW),
    .imem_rdata(imemRdataW), .redirect(redirectW), .redirect_pc(redirectPcW),
    .out_valid(outValidW), .out_ready(outReadyW), .out_pc(outPcW),
    .out_pcAdd4(outPcAdd4W), .out_inst(outInstW), .q_count(qCountW)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction memory, one-cycle latency, word = A000_0000 | address.
  always @(posedge clock) begin
    if (imemReq)  imemRdata  <= 32'hA000_0000 | imemAddr;
    if (imemReqW) imemRdataW <= 32'hA000_0000 | imemAddrW;
  end

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        valid;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [31:0] rp, input logic rdy,
                     input logic v, input logic [31:0] p, input logic q,
                     input logic [31:0] a, input int c);
    vecs.push_back('{r, rp, rdy, v, p, q, a, c[2:0]});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0; resetW = 1'b0;
    redirect = 1'b0; redirectPc = '0; outReady = 1'b0;
    redirectW = 1'b0; redirectPcW = '0; outReadyW = 1'b1;

    // Streaming, then 10 stall cycles, then redirect with 3 queued + 1 in flight,
    // then a misaligned redirect coinciding with a head transfer.
    add(0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, 4, 0);
    add(0, 0, 1, 1, 0, 1, 8, 1);
    add(0, 0, 1, 1, 4, 1, 12, 1);
    add(0, 0, 1, 1, 8, 1, 16, 1);
    add(0, 0, 1, 1, 12, 1, 20, 1);
    add(0, 0, 0, 1, 16, 1, 24, 1);
    add(0, 0, 0, 1, 16, 1, 28, 2);
    add(0, 0, 0, 1, 16, 0, 32, 3);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 16, 0, 32, 4);
    add(0, 0, 1, 1, 16, 0, 32, 4);
    add(0, 0, 1, 1, 20, 1, 32, 3);
    add(0, 0, 1, 1, 24, 1, 36, 2);
    add(0, 0, 1, 1, 28, 1, 40, 2);
    add(0, 0, 0, 1, 32, 1, 44, 2);
    add(1, 32'h100, 0, 1, 32, 0, 48, 3);
    add(0, 0, 0, 0, 0, 1, 32'h100, 0);
    add(0, 0, 0, 0, 0, 1, 32'h104, 0);
    add(1, 32'h203, 1, 1, 32'h100, 0, 32'h108, 1);
    add(0, 0, 1, 0, 0, 1, 32'h200, 0);
    add(0, 0, 1, 0, 0, 1, 32'h204, 0);
    add(0, 0, 1, 1, 32'h200, 1, 32'h208, 1);

    #2;
    check("rst_valid", 32'(outValid), 0);
    check("rst_req", 32'(imemReq), 0);
    check("rst_count", 32'(qCount), 0);
    check("rst_pc", outPc, 0);
    check("rst_pcadd4", outPcAdd4, 0);
    check("rst_inst", outInst, 0);

    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      redirect   = vecs[i].redir;
      redirectPc = vecs[i].rpc;
      outReady   = vecs[i].rdy;
      #1;
      check($sformatf("c%0d_valid", i), 32'(outValid), 32'(vecs[i].valid));
      check($sformatf("c%0d_pc", i), outPc, vecs[i].pc);
      check($sformatf("c%0d_pcadd4", i), outPcAdd4, vecs[i].valid ? vecs[i].pc + 32'd4 : 32'd0);
      check($sformatf("c%0d_inst", i), outInst, vecs[i].valid ? (32'hA000_0000 | vecs[i].pc) : 32'd0);
      check($sformatf("c%0d_req", i), 32'(imemReq), 32'(vecs[i].req));
      check($sformatf("c%0d_addr", i), imemAddr, vecs[i].addr);
      check($sformatf("c%0d_count", i), 32'(qCount), 32'(vecs[i].cnt));
      @(negedge clock);
    end

    // Fill the queue, then assert reset between edges.
    redirect = 1'b0; redirectPc = '0; outReady = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    check("full_count", 32'(qCount), 4);
    check("full_req", 32'(imemReq), 0);
    check("full_head", outPc, 32'h204);
    #1 reset = 1'b0;
    #1;
    check("arst_valid", 32'(outValid), 0);
    check("arst_req", 32'(imemReq), 0);
    check("arst_count", 32'(qCount), 0);
    check("arst_pc", outPc, 0);
    @(negedge clock);
    check("arst_hold_count", 32'(qCount), 0);
    reset = 1'b1;
    #1;
    check("rel_c0_req", 32'(imemReq), 1);
    check("rel_c0_addr", imemAddr, 0);
    @(negedge clock); #1;
    check("rel_c1_valid", 32'(outValid), 0);
    check("rel_c1_count", 32'(qCount), 0);
    @(negedge clock); #1;
    check("rel_c2_valid", 32'(outValid), 1);
    check("rel_c2_pc", outPc, 0);
    check("rel_c2_inst", outInst, 32'hA000_0000);

    // Wrap-around instance.
    @(negedge clock); #1;
    check("w_rst_req", 32'(imemReqW), 0);
    check("w_rst_valid", 32'(outValidW), 0);
    resetW = 1'b1;
    #1;
    check("w_c0_addr", imemAddrW, 32'hFFFF_FFF8);
    @(negedge clock); @(negedge clock); #1;
    check("w_c2_valid", 32'(outValidW), 1);
    check("w_c2_pc", outPcW, 32'hFFFF_FFF8);
    check("w_c2_pcadd4", outPcAdd4W, 32'hFFFF_FFFC);
    check("w_c2_inst", outInstW, 32'hFFFF_FFF8);
    @(negedge clock); #1;
    check("w_c3_pc", outPcW, 32'hFFFF_FFFC);
    check("w_c3_pcadd4", outPcAdd4W, 32'h0000_0000);
    check("w_c3_inst", outInstW, 32'hFFFF_FFFC);
    @(negedge clock); #1;
    check("w_c4_pc", outPcW, 32'h0000_0000);
    check("w_c4_pcadd4", outPcAdd4W, 32'h0000_0004);
    check("w_c4_inst", outInstW, 32'hA000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the 5-stage RV32I pipeline. It sits directly upstream of the IF/ID register and replaces the bare `pc <= newPC` logic in the top level.
- Owns the PC and issues word reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions in a small prefetch queue and presents {pc, pc+4, inst} to decode with a valid/ready handshake.
- Accepts redirects (taken branch/jal/jalr from the MEM stage) that flush all speculative fetch state.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, >=2.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- ADDR_W, 32, PC/address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- imem_req  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_W  word-aligned fetch address
- imem_rdata  in  32  instruction; valid the cycle after imem_req=1
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  restart target; bits[1:0] ignored
- out_valid  out  1  head entry available to IF/ID
- out_ready  in  1  IF/ID accepts (0 = decode stall)
- out_pc  out  ADDR_W  PC of head instruction
- out_pcAdd4  out  ADDR_W  out_pc + 4
- out_inst  out  32  head instruction word
- q_count  out  $clog2(DEPTH)+1  queue occupancy (debug/coverage)

Behaviour:
- **Reset (reset=0, async):**
  - fetch_pc = RESET_PC, queue empty, inflight = 0.
  - imem_req = 0, out_valid = 0, out_pc/out_pcAdd4/out_inst = 0, q_count = 0.
- **State:** fetch_pc; inflight (1 bit) plus inflight_pc; queue of {pc, inst} with rd/wr pointers and count.
- **Issue rule:**
  - imem_req = !redirect && (count + inflight < DEPTH), evaluated combinationally from registers.
  - imem_addr = fetch_pc. On issue, fetch_pc += 4 (wraps mod 2^ADDR_W), inflight <= 1, inflight_pc <= fetch_pc.
  - Without an issue, inflight <= 0.
- **Return:** if inflight=1 and no redirect in the current cycle, push {inflight_pc, imem_rdata} at the clock edge.
- **Output:**
  - out_valid = (count != 0).
  - out_* driven from the queue head with no bypass. out_pcAdd4 = head pc + 4.
  - Pop when out_valid && out_ready.
- **Simultaneous push+pop:** count unchanged, both pointers advance. Push into a full queue cannot occur because of the credit rule; the verifier asserts this.
- **Redirect (highest priority):**
  - Queue cleared (count = 0), inflight cleared; the in-flight response is discarded.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}. No imem_req in the redirect cycle.
  - A handshake in the same cycle still counts as a transfer; squashing that instruction is the downstream pipeline's job.
- **Latency:**
  - Reset released before edge 0: req at cycle 0, push at edge 1, out_valid in cycle 2.
  - Redirect at cycle R: req at R+1, out_valid at R+3.
- **Throughput:** 1 instruction/cycle sustained with out_ready=1.
- **Stall (out_ready=0):** queue fills to DEPTH, then imem_req stays 0. No instruction is lost or duplicated.
- **Reset mid-operation:** immediate return to reset state; the memory response in the following cycle is ignored.

Decomposition:
- Shared package `pipeline_pkg`:
  - RESET_PC default, INST_NOP = 32'h0000_0013.
  - fetch_entry_t {pc[ADDR_W-1:0], inst[31:0]}.
- One sub-module `fetch_queue`: synchronous FIFO, DEPTH x fetch_entry_t, with push/pop/flush, count, and head output without bypass.
- fetch_unit holds the PC, credit logic and inflight tracking.

Test Plan:
1. **Reset then streaming.** Release reset, out_ready=1, memory returns inst = 32'hA000_0000 | addr. Required: first out_valid at cycle 2 with out_pc=0, out_pcAdd4=4, out_inst=32'hA000_0000; then pc 4, 8, 12 on consecutive cycles.
2. **Backpressure.** Hold out_ready=0 for 10 cycles after streaming starts. Required: q_count saturates at 4, imem_req=0 once count+inflight=4. After release, pcs continue in order with no gap, loss or duplicate.
3. **Redirect with data in flight.** Redirect with redirect_pc=32'h0000_0100 while the queue holds 3 entries and inflight=1. Required: next cycle q_count=0, out_valid=0; imem_addr=0x100 at R+1; out_pc=0x100 at R+3; the stale response is not pushed.
4. **Misaligned redirect plus pop.** Redirect with redirect_pc=32'h0000_0203 and out_ready=1 in the same cycle. Required: the head is transferred that cycle, then a flush; next fetch address is 0x200.
5. **Wrap-around.** RESET_PC=32'hFFFF_FFF8. Required: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pcAdd4 for FFFF_FFFC is 0.
6. **Async reset mid-stream.** Assert reset between clock edges with a full queue. Required: out_valid, imem_req and q_count go to 0 immediately; after release the first out_pc is RESET_PC.
